// File: rtl/dbus_arbiter_if.sv
// Data-bus request/response types and the handshake interface shared by the
// two pipeline lanes and the single data bus.
package dbus_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

interface dbus_if;
  import dbus_pkg::*;

  dbus_req_t  req;
  dbus_resp_t resp;

  // The requester drives req; the responder answers on resp.
  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/dbus_arbiter.sv
// Two-to-one data-bus arbiter with grant locking until addr_ok and an owner
// FIFO that routes each data_ok back to the lane that issued it.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic   clk,
  input  logic   reset,
  dbus_if.slave  dbus0,
  dbus_if.slave  dbus1,
  dbus_if.master dbus
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {
    G_NONE,
    G_LANE0,
    G_LANE1
  } grant_t;

  grant_t     state, state_next;
  dbus_req_t  lreq, lreq_next;
  dbus_req_t  sel_req;
  logic       wd, wd_next;

  logic       fifo_owner [MAX_OUTSTANDING];
  logic       fifo_drop  [MAX_OUTSTANDING];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic full, presented, pres_owner, pres_drop;
  logic accept, bypass, push, pop;
  logic route_valid, route_owner, route_drop;

  // full depends only on registered count, keeping data_ok off the dreq.valid path
  assign full = (count == MAX_CNT);

  always_comb begin
    state_next = state;
    lreq_next  = lreq;
    wd_next    = wd;
    sel_req    = '0;
    dbus.req   = '0;
    presented  = 1'b0;
    pres_owner = 1'b0;
    pres_drop  = 1'b0;
    unique case (state)
      G_NONE: begin
        if (!full && (dbus0.req.valid || dbus1.req.valid)) begin
          presented  = 1'b1;
          pres_owner = !dbus0.req.valid;
          sel_req    = pres_owner ? dbus1.req : dbus0.req;
          dbus.req   = sel_req;
          if (!dbus.resp.addr_ok) begin
            state_next = pres_owner ? G_LANE1 : G_LANE0;
            lreq_next  = sel_req;
            wd_next    = 1'b0;
          end
        end
      end
      G_LANE0, G_LANE1: begin
        // The bus keeps seeing the latched copy even if the lane withdraws.
        presented      = 1'b1;
        pres_owner     = (state == G_LANE1);
        dbus.req       = lreq;
        dbus.req.valid = 1'b1;
        pres_drop      = wd | !(pres_owner ? dbus1.req.valid : dbus0.req.valid);
        wd_next        = pres_drop;
        if (dbus.resp.addr_ok) begin
          state_next = G_NONE;
          wd_next    = 1'b0;
        end
      end
      default: state_next = G_NONE;
    endcase
  end

  // A data_ok arriving with an empty FIFO belongs to the transaction accepted now.
  assign accept      = presented && dbus.resp.addr_ok;
  assign bypass      = accept && dbus.resp.data_ok && (count == '0);
  assign push        = accept && !bypass;
  assign pop         = dbus.resp.data_ok && (count != '0);
  assign route_valid = pop || bypass;
  assign route_owner = pop ? fifo_owner[head] : pres_owner;
  assign route_drop  = pop ? fifo_drop[head]  : pres_drop;

  assign dbus0.resp.addr_ok = accept && !pres_owner && !pres_drop;
  assign dbus1.resp.addr_ok = accept &&  pres_owner && !pres_drop;
  assign dbus0.resp.data_ok = dbus.resp.data_ok && route_valid && !route_owner && !route_drop;
  assign dbus1.resp.data_ok = dbus.resp.data_ok && route_valid &&  route_owner && !route_drop;
  assign dbus0.resp.data    = dbus.resp.data;
  assign dbus1.resp.data    = dbus.resp.data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= G_NONE;
      lreq  <= '0;
      wd    <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      lreq  <= lreq_next;
      wd    <= wd_next;
      if (push) tail <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
      if (pop)  head <= (head == LAST_PTR) ? '0 : head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_owner[tail] <= pres_owner;
      fifo_drop[tail]  <= pres_drop;
    end
  end

endmodule
